// File: rtl/booth_mult_32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_32_pkg
// Description : Shared types and constants for the sequential Booth
//               multiplier: FSM state encoding, datapath width, iteration
//               counter width and the index of the final iteration.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package booth_mult_32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mult_state_t;

  localparam int          MULT_WIDTH = 32;
  localparam int          MULT_CNT_W = 5;
  localparam logic [4:0]  MULT_LAST  = 5'd31;

endpackage : booth_mult_32_pkg
`default_nettype wire

// File: rtl/booth_step_32.sv
`default_nettype none
// ============================================================================
// Module      : booth_step_32
// Description : One radix-2 Booth iteration (combinational). Chooses the
//               adder operand/carry for add, subtract or no-op from
//               {lo[0], qm1}, then arithmetically shifts {hi', lo, qm1}
//               right by one, using the adder overflow to recover the true
//               sign of the 33-bit partial sum.
// Ports       : i_hi, i_lo, i_qm1 - current product register
//               i_m               - multiplicand
//               i_sum, i_ovf      - adder result for the selected operation
//               o_b, o_ci         - adder b operand and carry in
//               o_hi, o_lo, o_qm1 - shifted product register
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step_32
  import booth_mult_32_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] i_hi,
  input  logic [MULT_WIDTH-1:0] i_lo,
  input  logic                  i_qm1,
  input  logic [MULT_WIDTH-1:0] i_m,
  input  logic [MULT_WIDTH-1:0] i_sum,
  input  logic                  i_ovf,
  output logic [MULT_WIDTH-1:0] o_b,
  output logic                  o_ci,
  output logic [MULT_WIDTH-1:0] o_hi,
  output logic [MULT_WIDTH-1:0] o_lo,
  output logic                  o_qm1
);

  logic                  w_add;
  logic                  w_sub;
  logic                  w_op;
  logic [MULT_WIDTH-1:0] w_src;
  logic                  w_sign;

  assign w_add = ({i_lo[0], i_qm1} == 2'b01);
  assign w_sub = ({i_lo[0], i_qm1} == 2'b10);
  assign w_op  = w_add | w_sub;

  // Subtraction is hi + ~M + 1.
  assign o_b  = w_sub ? ~i_m : i_m;
  assign o_ci = w_sub;

  assign w_src  = w_op ? i_sum : i_hi;
  // sum[31] ^ ovf is bit 32 of the exact sum, so M = -2^31 still shifts in
  // the correct sign.
  assign w_sign = w_op ? (i_sum[MULT_WIDTH-1] ^ i_ovf) : i_hi[MULT_WIDTH-1];

  assign o_hi  = {w_sign, w_src[MULT_WIDTH-1:1]};
  assign o_lo  = {w_src[0], i_lo[MULT_WIDTH-1:1]};
  assign o_qm1 = i_lo[0];

endmodule : booth_step_32
`default_nettype wire

// File: rtl/csa_32.sv
`default_nettype none
// ============================================================================
// Module      : csa_32
// Description : 32-bit carry-select adder built from four 8-bit blocks. Each
//               block precomputes its sum for carry-in 0 and 1 and the
//               incoming block carry selects between them.
// Ports       : i_a, i_b  - 32-bit addends
//               i_ci      - carry in
//               o_sum     - 32-bit sum
//               o_co      - carry out of bit 31
//               o_ovf     - signed (two's complement) overflow
// Revision    : 1.0 - initial release
// ============================================================================
module csa_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_ci,
  output logic [31:0] o_sum,
  output logic        o_co,
  output logic        o_ovf
);

  logic [4:0] w_carry;

  assign w_carry[0] = i_ci;

  for (genvar k = 0; k < 4; k++) begin : g_blk
    logic [8:0] w_s0;
    logic [8:0] w_s1;
    assign w_s0 = {1'b0, i_a[8*k +: 8]} + {1'b0, i_b[8*k +: 8]};
    assign w_s1 = w_s0 + 9'd1;
    assign {w_carry[k+1], o_sum[8*k +: 8]} = w_carry[k] ? w_s1 : w_s0;
  end

  assign o_co  = w_carry[4];
  // Operands of equal sign producing a result of the other sign.
  assign o_ovf = (i_a[31] == i_b[31]) && (o_sum[31] != i_a[31]);

endmodule : csa_32
`default_nettype wire

// File: rtl/booth_mult_32.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_32
// Description : Sequential signed 32x32 radix-2 Booth multiplier, one
//               iteration per clock, all arithmetic through one csa_32.
//               Returns the low product word plus an overflow flag when the
//               64-bit product does not fit in signed 32 bits.
// Ports       : clock, reset     - clock, synchronous active-high reset
//               ctrl_mult        - start strobe (accepted in IDLE/DONE)
//               data_operandA/B  - multiplicand / multiplier
//               data_result      - low 32 bits of product (registered)
//               data_exception   - product overflow (registered)
//               data_resultRDY   - one-cycle result-valid pulse
//               busy             - iteration in progress
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_32 #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  import booth_mult_32_pkg::*;

  if (WIDTH != MULT_WIDTH || ITER != WIDTH) begin : g_bad_width
    $error("booth_mult_32 supports only WIDTH = ITER = 32");
  end

  mult_state_t            r_state;
  mult_state_t            w_next_state;
  logic [MULT_CNT_W-1:0]  r_count;
  logic [MULT_WIDTH-1:0]  r_m;
  logic [MULT_WIDTH-1:0]  r_hi;
  logic [MULT_WIDTH-1:0]  r_lo;
  logic                   r_qm1;
  logic [MULT_WIDTH-1:0]  r_result;
  logic                   r_exc;

  logic [MULT_WIDTH-1:0]  w_b;
  logic                   w_ci;
  logic [MULT_WIDTH-1:0]  w_sum;
  logic                   w_ovf;
  logic                   w_unused_co;
  logic [MULT_WIDTH-1:0]  w_nxt_hi;
  logic [MULT_WIDTH-1:0]  w_nxt_lo;
  logic                   w_nxt_qm1;
  logic                   w_accept;
  logic                   w_last;

  csa_32 u_adder (
    .i_a   (r_hi),
    .i_b   (w_b),
    .i_ci  (w_ci),
    .o_sum (w_sum),
    .o_co  (w_unused_co),
    .o_ovf (w_ovf)
  );

  booth_step_32 u_step (
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_qm1 (r_qm1),
    .i_m   (r_m),
    .i_sum (w_sum),
    .i_ovf (w_ovf),
    .o_b   (w_b),
    .o_ci  (w_ci),
    .o_hi  (w_nxt_hi),
    .o_lo  (w_nxt_lo),
    .o_qm1 (w_nxt_qm1)
  );

  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && ctrl_mult;
  assign w_last   = (r_state == ST_RUN) && (r_count == MULT_LAST);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (ctrl_mult) w_next_state = ST_RUN;
      ST_RUN:  if (r_count == MULT_LAST) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ctrl_mult ? ST_RUN : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy           = (r_state == ST_RUN);
    data_resultRDY = (r_state == ST_DONE);
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count  <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_qm1    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_m     <= data_operandA;
      r_hi    <= '0;
      r_lo    <= data_operandB;
      r_qm1   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_hi    <= w_nxt_hi;
      r_lo    <= w_nxt_lo;
      r_qm1   <= w_nxt_qm1;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        // Product fits iff the high word is pure sign extension of the low.
        r_result <= w_nxt_lo;
        r_exc    <= (w_nxt_hi != {MULT_WIDTH{w_nxt_lo[MULT_WIDTH-1]}});
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;

endmodule : booth_mult_32
`default_nettype wire

// File: tb/tb_booth_mult_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult_32
// Description : Directed and random self-checking bench for booth_mult_32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_32;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_mult;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  booth_mult_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Starts one multiply and waits (bounded) for RDY. ncyc counts edges from
  // the accepting edge up to the edge after which RDY is seen.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          output int ncyc, output int nbusy);
    ctrl_mult     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    ncyc  = 0;
    nbusy = 0;
    @(posedge clock); #1;
    ctrl_mult = 1'b0;
    ncyc = 1;
    if (busy) nbusy++;
    while (!data_resultRDY && ncyc < 100) begin
      @(posedge clock); #1;
      ncyc++;
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_mult = 1'b1;
    data_operandA = 32'd5; data_operandB = 32'd5;
    repeat (2) @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    n_cmp++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    int nc, nb;
    run_mult(32'd3, 32'hFFFFFFFB, nc, nb);
    n_cmp++;
    if (nc !== 33) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles, want 33", nc);
    end
    n_cmp++;
    if (data_result !== 32'hFFFFFFF1 || data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got %h/%b, want fffffff1/0", data_result, data_exception);
    end
    n_cmp++;
    if (nb !== 32) begin
      n_fail++; $display("FAIL basic_busy: busy %0d cycles, want 32", nb);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'hFFFFFFF1) begin
      n_fail++;
      $display("FAIL rdy_pulse_hold: rdy=%b res=%h, want 0/fffffff1", data_resultRDY, data_result);
    end
  endtask

  task automatic test_corners();
    logic [31:0] va [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] vb [4] = '{32'h00000002, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] er [4] = '{32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'h00000000};
    logic        ee [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int nc, nb;
    for (int i = 0; i < 4; i++) begin
      run_mult(va[i], vb[i], nc, nb);
      n_cmp++;
      if (nc !== 33 || data_result !== er[i] || data_exception !== ee[i]) begin
        n_fail++;
        $display("FAIL corner_%0d: got %h/%b in %0d cycles, want %h/%b in 33",
                 i, data_result, data_exception, nc, er[i], ee[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int nc, nb;
    ctrl_mult = 1'b1; data_operandA = 32'd7; data_operandB = 32'd6;
    @(posedge clock); #1;
    ctrl_mult = 1'b0;
    n = 1;
    repeat (9) begin @(posedge clock); #1; n++; end
    // Start strobe while busy must be ignored.
    ctrl_mult = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
    @(posedge clock); #1;
    ctrl_mult = 1'b0;
    n++;
    while (!data_resultRDY && n < 100) begin @(posedge clock); #1; n++; end
    n_cmp++;
    if (n !== 33 || data_result !== 32'd42 || data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy: got %0d/%b in %0d cycles, want 42/0 in 33",
               data_result, data_exception, n);
    end
    // Restart from the DONE cycle.
    run_mult(32'hFFFFFFFC, 32'hFFFFFFFC, nc, nb);
    n_cmp++;
    if (nb !== 32) begin
      n_fail++; $display("FAIL b2b_accept: busy %0d cycles, want 32", nb);
    end
    n_cmp++;
    if (nc !== 33 || data_result !== 32'd16 || data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: got %0d/%b in %0d cycles, want 16/0 in 33",
               data_result, data_exception, nc);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int nc, nb;
    int rdy_seen;
    ctrl_mult = 1'b1; data_operandA = 32'd100; data_operandB = 32'd100;
    @(posedge clock); #1;
    ctrl_mult = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got res=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY || busy) rdy_seen++;
    end
    n_cmp++;
    if (rdy_seen !== 0) begin
      n_fail++; $display("FAIL reset_abandon: rdy/busy seen %0d cycles, want 0", rdy_seen);
    end
    run_mult(32'd0, 32'd12345, nc, nb);
    n_cmp++;
    if (nc !== 33 || data_result !== 32'd0 || data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got %h/%b in %0d cycles, want 0/0 in 33",
               data_result, data_exception, nc);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int nc, nb;
    logic [31:0] a, b;
    logic signed [63:0] p;
    logic        exp_exc;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = {{24{a[7]}}, a[7:0]};
      if (i % 4 == 2) b = {{20{b[11]}}, b[11:0]};
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      exp_exc = (p[63:32] != {32{p[31]}});
      run_mult(a, b, nc, nb);
      n_cmp++;
      if (nc !== 33 || data_result !== p[31:0] || data_exception !== exp_exc) begin
        n_fail++;
        $display("FAIL random_%0d: %h*%h got %h/%b in %0d cycles, want %h/%b in 33",
                 i, a, b, data_result, data_exception, nc, p[31:0], exp_exc);
      end
      if (i % 3 == 0) begin @(posedge clock); #1; end
    end
  endtask

  initial begin
    reset = 1'b1; ctrl_mult = 1'b0;
    data_operandA = '0; data_operandB = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_booth_mult_32
`default_nettype wire
